// File: rtl/chimera_clu_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// chimera_clu_pwr_ctrl
//
// Per-cluster power/isolation sequencer in the SoC clock domain. Each cluster
// has its own FSM. The FSM turns a level enable request into an ordered
// power-up or power-down sequence:
//   power-up  : clock on -> reset released -> isolation released -> ON
//   power-down: isolation requested -> clock gated -> reset asserted -> OFF
// A sticky error flag is set if the isolation handshake does not complete
// in time.
//
// Ports (all vectors are NumClusters wide, one bit per cluster):
//   clk_i        in   SoC clock
//   rst_i        in   asynchronous, active-high reset
//   en_req_i     in   requested cluster state (1 = on), level
//   isolated_i   in   isolation status from the cluster domain (1 = isolated)
//   err_clr_i    in   single-cycle pulse that clears err_o
//   isolate_o    out  isolation request to the cluster domain
//   clu_clk_en_o out  cluster clock-gate enable
//   clu_rst_no   out  active-low cluster reset
//   busy_o       out  1 while a sequence is in progress (not OFF, not ON)
//   err_o        out  sticky handshake-timeout flag
// ---------------------------------------------------------------------------
module chimera_clu_pwr_ctrl #(
    parameter int NumClusters   = 5,
    parameter int RstCycles     = 4,
    parameter int SettleCycles  = 2,
    parameter int TimeoutCycles = 1024
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NumClusters-1:0] en_req_i,
    input  logic [NumClusters-1:0] isolated_i,
    input  logic [NumClusters-1:0] err_clr_i,
    output logic [NumClusters-1:0] isolate_o,
    output logic [NumClusters-1:0] clu_clk_en_o,
    output logic [NumClusters-1:0] clu_rst_no,
    output logic [NumClusters-1:0] busy_o,
    output logic [NumClusters-1:0] err_o
);

    // Counter is wide enough for the longest load value of any phase.
    localparam int MaxA      = (RstCycles > SettleCycles) ? RstCycles : SettleCycles;
    localparam int MaxCycles = (MaxA > TimeoutCycles) ? MaxA : TimeoutCycles;
    localparam int CntWidth  = $clog2(MaxCycles + 1);

    localparam logic [CntWidth-1:0] RstLoad     = CntWidth'(RstCycles - 1);
    localparam logic [CntWidth-1:0] SettleLoad  = CntWidth'(SettleCycles - 1);
    localparam logic [CntWidth-1:0] TimeoutLoad = CntWidth'(TimeoutCycles - 1);

    typedef enum logic [2:0] {
        S_OFF,
        S_CLK_ON,
        S_RST_REL,
        S_UNISO,
        S_ON,
        S_ISO,
        S_GATE
    } state_t;

    typedef struct packed {
        logic isolate;
        logic clk_en;
        logic rst_n;
        logic busy;
    } outs_t;

    // Output pattern of each state. Outputs are registered together with the
    // state, so every transition loads decode(next_state).
    function automatic outs_t decode(input state_t s);
        outs_t o;
        o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, busy: 1'b0};
        unique case (s)
            S_OFF:     o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, busy: 1'b0};
            S_CLK_ON:  o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b0, busy: 1'b1};
            S_RST_REL: o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b1};
            S_UNISO:   o = '{isolate: 1'b0, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b1};
            S_ON:      o = '{isolate: 1'b0, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b0};
            S_ISO:     o = '{isolate: 1'b1, clk_en: 1'b1, rst_n: 1'b1, busy: 1'b1};
            S_GATE:    o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b1, busy: 1'b1};
            default:   o = '{isolate: 1'b1, clk_en: 1'b0, rst_n: 1'b0, busy: 1'b0};
        endcase
        return o;
    endfunction

    for (genvar g = 0; g < NumClusters; g++) begin : g_clu
        state_t              state;
        logic [CntWidth-1:0] cnt;
        outs_t               outs;
        logic                err;

        // NOTE: all state here is updated with non-blocking assignments, so
        // every branch reads the values from before this edge.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                state <= S_OFF;
                cnt   <= '0;
                outs  <= decode(S_OFF);
                err   <= 1'b0;
            end else begin
                // NOTE: the clear is written first so that a timeout set
                // further down in the same edge overrides it (set wins).
                if (err_clr_i[g]) begin
                    err <= 1'b0;
                end

                unique case (state)
                    S_OFF: begin
                        if (en_req_i[g]) begin
                            state <= S_CLK_ON;
                            outs  <= decode(S_CLK_ON);
                            cnt   <= RstLoad;
                        end
                    end

                    // Clock runs with reset held for RstCycles edges.
                    S_CLK_ON: begin
                        if (cnt == '0) begin
                            state <= S_RST_REL;
                            outs  <= decode(S_RST_REL);
                            cnt   <= SettleLoad;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    // Reset released; let the cluster settle before unisolating.
                    S_RST_REL: begin
                        if (cnt == '0) begin
                            state <= S_UNISO;
                            outs  <= decode(S_UNISO);
                            cnt   <= TimeoutLoad;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    // Waiting for the domain to drop isolation. On timeout the
                    // counter sits at 0 and the error keeps being asserted.
                    S_UNISO: begin
                        if (!isolated_i[g]) begin
                            state <= S_ON;
                            outs  <= decode(S_ON);
                        end else if (cnt == '0) begin
                            err <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    S_ON: begin
                        if (!en_req_i[g]) begin
                            state <= S_ISO;
                            outs  <= decode(S_ISO);
                            cnt   <= TimeoutLoad;
                        end
                    end

                    // Waiting for isolation to be confirmed. A confirmed
                    // isolation takes priority over a re-request, so a
                    // power-down that has already isolated always completes.
                    S_ISO: begin
                        if (isolated_i[g]) begin
                            state <= S_GATE;
                            outs  <= decode(S_GATE);
                            cnt   <= SettleLoad;
                        end else if (en_req_i[g]) begin
                            state <= S_UNISO;
                            outs  <= decode(S_UNISO);
                            cnt   <= TimeoutLoad;
                        end else if (cnt == '0) begin
                            err <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    // Clock gated; reset is asserted only after settling.
                    S_GATE: begin
                        if (cnt == '0) begin
                            state <= S_OFF;
                            outs  <= decode(S_OFF);
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end

                    default: begin
                        state <= S_OFF;
                        outs  <= decode(S_OFF);
                        cnt   <= '0;
                    end
                endcase
            end
        end

        assign isolate_o[g]    = outs.isolate;
        assign clu_clk_en_o[g] = outs.clk_en;
        assign clu_rst_no[g]   = outs.rst_n;
        assign busy_o[g]       = outs.busy;
        assign err_o[g]        = err;
    end

endmodule

// File: tb/tb_chimera_clu_pwr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_chimera_clu_pwr_ctrl
//
// Self-checking bench for chimera_clu_pwr_ctrl. A phase/elapsed-time model
// of each cluster's sequence predicts all outputs, and a compare process
// checks every output bit on every falling edge. Directed scenarios add
// hand-computed literal expectations at the key edges of each sequence.
// ---------------------------------------------------------------------------
module tb_chimera_clu_pwr_ctrl;

    localparam int N   = 5;
    localparam int RST = 4;
    localparam int SET = 2;
    localparam int TO  = 16;

    logic         clk_i = 1'b0;
    logic         rst_i = 1'b0;
    logic [N-1:0] en_req_i;
    logic [N-1:0] isolated_i;
    logic [N-1:0] err_clr_i;
    logic [N-1:0] isolate_o;
    logic [N-1:0] clu_clk_en_o;
    logic [N-1:0] clu_rst_no;
    logic [N-1:0] busy_o;
    logic [N-1:0] err_o;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    chimera_clu_pwr_ctrl #(
        .NumClusters  (N),
        .RstCycles    (RST),
        .SettleCycles (SET),
        .TimeoutCycles(TO)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .en_req_i    (en_req_i),
        .isolated_i  (isolated_i),
        .err_clr_i   (err_clr_i),
        .isolate_o   (isolate_o),
        .clu_clk_en_o(clu_clk_en_o),
        .clu_rst_no  (clu_rst_no),
        .busy_o      (busy_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Phases of the sequence; m_el counts edges spent in the current phase.
    localparam int PH_OFF   = 0;
    localparam int PH_CLK   = 1;  // clock on, reset held
    localparam int PH_SETL  = 2;  // reset released, settling
    localparam int PH_WUNI  = 3;  // waiting for isolation to drop
    localparam int PH_ON    = 4;
    localparam int PH_WISO  = 5;  // waiting for isolation to be confirmed
    localparam int PH_GATED = 6;  // clock gated, settling before reset

    int   m_ph  [N];
    int   m_el  [N];
    logic m_err [N];

    // {isolate, clk_en, rst_n, busy} for each phase.
    function automatic logic [3:0] phase_outs(input int ph);
        case (ph)
            PH_OFF:   return 4'b1000;
            PH_CLK:   return 4'b1101;
            PH_SETL:  return 4'b1111;
            PH_WUNI:  return 4'b0111;
            PH_ON:    return 4'b0110;
            PH_WISO:  return 4'b1111;
            PH_GATED: return 4'b1011;
            default:  return 4'b1000;
        endcase
    endfunction

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int c = 0; c < N; c++) begin
                m_ph[c]  <= PH_OFF;
                m_el[c]  <= 0;
                m_err[c] <= 1'b0;
            end
        end else begin
            for (int c = 0; c < N; c++) begin
                if (err_clr_i[c]) m_err[c] <= 1'b0;
                case (m_ph[c])
                    PH_OFF: if (en_req_i[c]) begin m_ph[c] <= PH_CLK; m_el[c] <= 0; end
                    PH_CLK: begin
                        if (m_el[c] == RST - 1) begin m_ph[c] <= PH_SETL; m_el[c] <= 0; end
                        else m_el[c] <= m_el[c] + 1;
                    end
                    PH_SETL: begin
                        if (m_el[c] == SET - 1) begin m_ph[c] <= PH_WUNI; m_el[c] <= 0; end
                        else m_el[c] <= m_el[c] + 1;
                    end
                    PH_WUNI: begin
                        if (!isolated_i[c]) m_ph[c] <= PH_ON;
                        else if (m_el[c] == TO - 1) m_err[c] <= 1'b1;
                        else m_el[c] <= m_el[c] + 1;
                    end
                    PH_ON: if (!en_req_i[c]) begin m_ph[c] <= PH_WISO; m_el[c] <= 0; end
                    PH_WISO: begin
                        if (isolated_i[c]) begin m_ph[c] <= PH_GATED; m_el[c] <= 0; end
                        else if (en_req_i[c]) begin m_ph[c] <= PH_WUNI; m_el[c] <= 0; end
                        else if (m_el[c] == TO - 1) m_err[c] <= 1'b1;
                        else m_el[c] <= m_el[c] + 1;
                    end
                    PH_GATED: begin
                        if (m_el[c] == SET - 1) begin m_ph[c] <= PH_OFF; m_el[c] <= 0; end
                        else m_el[c] <= m_el[c] + 1;
                    end
                    default: m_ph[c] <= PH_OFF;
                endcase
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk_i) begin : cmp
        logic [N-1:0] e_iso, e_clk, e_rstn, e_busy, e_err;
        logic [3:0]   o;
        if (cmp_en) begin
            for (int c = 0; c < N; c++) begin
                o         = phase_outs(m_ph[c]);
                e_iso[c]  = o[3];
                e_clk[c]  = o[2];
                e_rstn[c] = o[1];
                e_busy[c] = o[0];
                e_err[c]  = m_err[c];
            end
            check("model_isolate", 32'(isolate_o), 32'(e_iso));
            check("model_clk_en", 32'(clu_clk_en_o), 32'(e_clk));
            check("model_rst_n", 32'(clu_rst_no), 32'(e_rstn));
            check("model_busy", 32'(busy_o), 32'(e_busy));
            check("model_err", 32'(err_o), 32'(e_err));
        end
    end

    // Advance n rising edges, ending just after the following falling edge.
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_i);
            @(negedge clk_i);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_isolate"}, 32'(isolate_o), 32'h1f);
        check({tag, "_clk_en"}, 32'(clu_clk_en_o), 32'h00);
        check({tag, "_rst_n"}, 32'(clu_rst_no), 32'h00);
        check({tag, "_busy"}, 32'(busy_o), 32'h00);
        check({tag, "_err"}, 32'(err_o), 32'h00);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        en_req_i   = '0;
        isolated_i = '1;
        err_clr_i  = '0;

        #3 rst_i = 1'b1;
        @(negedge clk_i);
        check_reset_vals("reset");
        @(negedge clk_i);
        rst_i  = 1'b0;
        cmp_en = 1'b1;

        // Power-up of cluster 0; edges counted from the first sampling edge.
        en_req_i[0] = 1'b1;
        tick(1);
        check("pu_e1_clk_en", 32'(clu_clk_en_o[0]), 32'd1);
        check("pu_e1_rst_n", 32'(clu_rst_no[0]), 32'd0);
        tick(3);
        check("pu_e4_rst_n", 32'(clu_rst_no[0]), 32'd0);
        tick(1);
        check("pu_e5_rst_n", 32'(clu_rst_no[0]), 32'd1);
        tick(1);
        check("pu_e6_isolate", 32'(isolate_o[0]), 32'd1);
        tick(1);
        check("pu_e7_isolate", 32'(isolate_o[0]), 32'd0);
        tick(3);
        check("pu_e10_busy", 32'(busy_o[0]), 32'd1);
        isolated_i[0] = 1'b0;
        tick(1);
        check("pu_e11_busy", 32'(busy_o[0]), 32'd0);
        check("pu_e11_err", 32'(err_o[0]), 32'd0);

        // Power-down of cluster 0; isolation confirmed 5 cycles after request.
        en_req_i[0] = 1'b0;
        tick(1);
        check("pd_iso_isolate", 32'(isolate_o[0]), 32'd1);
        check("pd_iso_clk_en", 32'(clu_clk_en_o[0]), 32'd1);
        tick(5);
        isolated_i[0] = 1'b1;
        tick(1);
        check("pd_gate_clk_en", 32'(clu_clk_en_o[0]), 32'd0);
        check("pd_gate_rst_n", 32'(clu_rst_no[0]), 32'd1);
        tick(1);
        check("pd_gate2_rst_n", 32'(clu_rst_no[0]), 32'd1);
        tick(1);
        check("pd_off_rst_n", 32'(clu_rst_no[0]), 32'd0);
        check("pd_off_busy", 32'(busy_o[0]), 32'd0);

        // Timeout on cluster 1 while waiting for isolation in ISO.
        en_req_i[1] = 1'b1;
        tick(7);
        isolated_i[1] = 1'b0;
        tick(1);
        en_req_i[1] = 1'b0;
        tick(1);                       // ISO entry edge
        tick(15);
        check("to_e15_err", 32'(err_o[1]), 32'd0);
        err_clr_i[1] = 1'b1;           // coincides with the timeout edge
        tick(1);
        err_clr_i[1] = 1'b0;
        check("to_e16_err", 32'(err_o[1]), 32'd1);
        check("to_e16_clk_en", 32'(clu_clk_en_o[1]), 32'd1);
        check("to_e16_isolate", 32'(isolate_o[1]), 32'd1);
        tick(3);
        check("to_sticky_err", 32'(err_o[1]), 32'd1);
        isolated_i[1] = 1'b1;
        tick(1);
        check("to_gate_clk_en", 32'(clu_clk_en_o[1]), 32'd0);
        err_clr_i[1] = 1'b1;
        tick(1);
        err_clr_i[1] = 1'b0;
        check("to_clr_err", 32'(err_o[1]), 32'd0);
        tick(1);
        check("to_off_busy", 32'(busy_o[1]), 32'd0);

        // Abort on cluster 2: re-request while still in ISO.
        en_req_i[2] = 1'b1;
        tick(7);
        isolated_i[2] = 1'b0;
        tick(1);
        en_req_i[2] = 1'b0;
        tick(1);
        check("ab_iso_isolate", 32'(isolate_o[2]), 32'd1);
        en_req_i[2] = 1'b1;
        tick(1);
        check("ab_uniso_isolate", 32'(isolate_o[2]), 32'd0);
        check("ab_uniso_busy", 32'(busy_o[2]), 32'd1);
        tick(1);
        check("ab_on_busy", 32'(busy_o[2]), 32'd0);
        // Same-cycle isolation and re-request: GATE wins.
        en_req_i[2] = 1'b0;
        tick(1);
        isolated_i[2] = 1'b1;
        en_req_i[2]   = 1'b1;
        tick(1);
        check("ab_gate_clk_en", 32'(clu_clk_en_o[2]), 32'd0);
        check("ab_gate_busy", 32'(busy_o[2]), 32'd1);
        tick(2);
        check("ab_off_rst_n", 32'(clu_rst_no[2]), 32'd0);
        check("ab_off_busy", 32'(busy_o[2]), 32'd0);
        tick(1);
        check("ab_restart_clk_en", 32'(clu_clk_en_o[2]), 32'd1);
        tick(6);
        isolated_i[2] = 1'b0;
        tick(1);
        check("ab_restart_on", 32'(busy_o[2]), 32'd0);

        // Reset asserted mid-cycle while cluster 3 is in RST_REL.
        en_req_i[3] = 1'b1;
        tick(5);
        check("rs_rstrel_rst_n", 32'(clu_rst_no[3]), 32'd1);
        #2 rst_i = 1'b1;
        #1 check_reset_vals("rst_in_rstrel");
        @(negedge clk_i);
        rst_i = 1'b0;
        tick(1);
        check("rs_restart_clk_en", 32'(clu_clk_en_o), 32'b01100);
        tick(6);
        isolated_i[3] = 1'b0;
        tick(1);
        check("rs_on_busy", 32'(busy_o), 32'b00000);
        check("rs_on_isolate", 32'(isolate_o), 32'b10011);
        // Async reset between edges while in ON.
        @(posedge clk_i);
        #2 rst_i = 1'b1;
        #1 check_reset_vals("rst_in_on");
        @(negedge clk_i);
        en_req_i   = '0;
        isolated_i = '1;
        rst_i      = 1'b0;
        tick(1);

        // Staggered clusters 0 and 4.
        en_req_i[0] = 1'b1;
        tick(2);
        check("st_e2_clk_en", 32'(clu_clk_en_o), 32'b00001);
        en_req_i[4] = 1'b1;
        tick(1);
        check("st_e3_clk_en", 32'(clu_clk_en_o), 32'b10001);
        check("st_e3_rst_n", 32'(clu_rst_no), 32'b00000);
        tick(2);
        check("st_e5_rst_n", 32'(clu_rst_no), 32'b00001);
        tick(2);
        check("st_e7_isolate", 32'(isolate_o), 32'b11110);
        check("st_e7_rst_n", 32'(clu_rst_no), 32'b10001);
        isolated_i[0] = 1'b0;
        tick(2);
        check("st_e9_busy", 32'(busy_o), 32'b10000);
        check("st_e9_isolate", 32'(isolate_o), 32'b01110);
        isolated_i[4] = 1'b0;
        tick(1);
        check("st_e10_busy", 32'(busy_o), 32'b00000);
        tick(2);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Safety net: the directed sequence is fixed-length, but never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
